stack_ptr_unit: RTL and testbench

- Parametrised stack-pointer engine for the stack CPU; replaces the fixed main/return pointer registers driven by the multicycle control FSM's pop/write strobes.
- Manages NUM_STACKS independent downward-growing hardware stacks (stack 0 = main, stack 1 = return by default).
- Provides precomputed memory addresses for the datapath, occupancy counts, full/empty flags, and overflow/underflow detection with sticky error bits.
- Accepts one operation per cycle from the control unit.

---
 rtl/stack_ptr_unit.sv | 160 ++++++++++++++++
 tb/tb_stack_ptr_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ptr_unit.sv
// Stack-pointer engine: NUM_STACKS downward-growing hardware stacks with
// precomputed top/push addresses, occupancy counts and overflow/underflow flags.
module stack_ptr_unit #(
  parameter int ADDR_W = 16,
  parameter int NUM_STACKS = 2,
  parameter int DEPTH = 256,
  parameter logic [NUM_STACKS*ADDR_W-1:0] STACK_BASE = {16'hFE00, 16'hFF00},
  localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  input  logic [1:0]                   op,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         err_clr,
  output logic [ADDR_W-1:0]            top_addr,
  output logic [ADDR_W-1:0]            push_addr,
  output logic [NUM_STACKS*ADDR_W-1:0] sp_all,
  output logic [NUM_STACKS*CNT_W-1:0]  cnt_all,
  output logic [NUM_STACKS-1:0]        empty,
  output logic [NUM_STACKS-1:0]        full,
  output logic                         ovf_pulse,
  output logic                         unf_pulse,
  output logic [NUM_STACKS-1:0]        err_ovf,
  output logic [NUM_STACKS-1:0]        err_unf
);

  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Reject illegal configurations at elaboration time.
  if (NUM_STACKS < 1 || NUM_STACKS > 8) begin : g_bad_num
    $error("stack_ptr_unit: NUM_STACKS must be 1..8");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("stack_ptr_unit: DEPTH must be at least 1");
  end
  for (genvar g = 0; g < NUM_STACKS; g++) begin : g_chk
    if (DEPTH > int'(STACK_BASE[g*ADDR_W +: ADDR_W])) begin : g_bad_base
      $error("stack_ptr_unit: DEPTH exceeds STACK_BASE of a stack");
    end
  end

  // Exclusive upper bound of stack i (its pointer value when empty).
  function automatic logic [ADDR_W-1:0] base_of(input int i);
    return STACK_BASE[i*ADDR_W +: ADDR_W];
  endfunction

  // A push is accepted only while there is room left.
  function automatic logic can_push(input logic [CNT_W-1:0] c);
    return c != CNT_W'(DEPTH);
  endfunction

  // A pop is accepted only while the stack holds something.
  function automatic logic can_pop(input logic [CNT_W-1:0] c);
    return c != '0;
  endfunction

  logic [ADDR_W-1:0]     sp_p1  [NUM_STACKS];
  logic [CNT_W-1:0]      cnt_p1 [NUM_STACKS];
  logic [NUM_STACKS-1:0] eo_p1, eu_p1;
  logic                  ovf_p1, unf_p1;

  logic                  sel_ok;
  logic [ADDR_W-1:0]     cur_sp, nxt_sp;
  logic [CNT_W-1:0]      cur_cnt, nxt_cnt;
  logic                  wr_en, rej_push, rej_pop;
  logic [NUM_STACKS-1:0] ovf_set, unf_set;

  // Decode the operation against the selected stack and form its next state.
  always_comb begin
    sel_ok   = int'(sel) < NUM_STACKS;
    cur_sp   = '0;
    cur_cnt  = '0;
    nxt_sp   = '0;
    nxt_cnt  = '0;
    wr_en    = 1'b0;
    rej_push = 1'b0;
    rej_pop  = 1'b0;
    ovf_set  = '0;
    unf_set  = '0;
    if (sel_ok) begin
      cur_sp  = sp_p1[sel];
      cur_cnt = cnt_p1[sel];
    end
    nxt_sp  = cur_sp;
    nxt_cnt = cur_cnt;
    if (op_valid && sel_ok) begin
      case (op)
        OP_PUSH: begin
          if (can_push(cur_cnt)) begin
            wr_en   = 1'b1;
            nxt_sp  = cur_sp - ADDR_W'(1);
            nxt_cnt = cur_cnt + CNT_W'(1);
          end else begin
            rej_push = 1'b1;
            ovf_set  = NUM_STACKS'(1) << sel;
          end
        end
        OP_POP: begin
          if (can_pop(cur_cnt)) begin
            wr_en   = 1'b1;
            nxt_sp  = cur_sp + ADDR_W'(1);
            nxt_cnt = cur_cnt - CNT_W'(1);
          end else begin
            rej_pop = 1'b1;
            unf_set = NUM_STACKS'(1) << sel;
          end
        end
        OP_CLEAR: begin
          wr_en   = 1'b1;
          nxt_sp  = base_of(int'(sel));
          nxt_cnt = '0;
        end
        default: ;
      endcase
    end
  end

  // Pointer/count state, error pulses and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STACKS; i++) begin
        sp_p1[i]  <= base_of(i);
        cnt_p1[i] <= '0;
      end
      eo_p1  <= '0;
      eu_p1  <= '0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      if (wr_en) begin
        sp_p1[sel]  <= nxt_sp;
        cnt_p1[sel] <= nxt_cnt;
      end
      ovf_p1 <= rej_push;
      unf_p1 <= rej_pop;
      eo_p1  <= (err_clr ? '0 : eo_p1) | ovf_set;
      eu_p1  <= (err_clr ? '0 : eu_p1) | unf_set;
    end
  end

  // Flatten per-stack state onto the packed status buses.
  for (genvar g = 0; g < NUM_STACKS; g++) begin : g_out
    assign sp_all[g*ADDR_W +: ADDR_W] = sp_p1[g];
    assign cnt_all[g*CNT_W +: CNT_W]  = cnt_p1[g];
    assign empty[g] = (cnt_p1[g] == '0);
    assign full[g]  = (cnt_p1[g] == CNT_W'(DEPTH));
  end

  assign top_addr  = cur_sp;
  assign push_addr = cur_sp - ADDR_W'(1);
  assign ovf_pulse = ovf_p1;
  assign unf_pulse = unf_p1;
  assign err_ovf   = eo_p1;
  assign err_unf   = eu_p1;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Bench for stack_ptr_unit: a default instance (2 stacks, depth 256) and a
// small instance (3 stacks, depth 4) checked against a scoreboard model.
module tb_stack_ptr_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        a_op_valid = 0, a_err_clr = 0;
  logic [1:0]  a_op = 0;
  logic [0:0]  a_sel = 0;
  logic [15:0] a_top, a_push;
  logic [31:0] a_sp_all;
  logic [17:0] a_cnt_all;
  logic [1:0]  a_empty, a_full, a_eo, a_eu;
  logic        a_ovf, a_unf;

  // Small instance
  logic        b_op_valid = 0, b_err_clr = 0;
  logic [1:0]  b_op = 0;
  logic [1:0]  b_sel = 0;
  logic [15:0] b_top, b_push;
  logic [47:0] b_sp_all;
  logic [8:0]  b_cnt_all;
  logic [2:0]  b_empty, b_full, b_eo, b_eu;
  logic        b_ovf, b_unf;

  stack_ptr_unit dut_a (
    .clk(clk), .rst(rst), .op_valid(a_op_valid), .op(a_op), .sel(a_sel),
    .err_clr(a_err_clr), .top_addr(a_top), .push_addr(a_push),
    .sp_all(a_sp_all), .cnt_all(a_cnt_all), .empty(a_empty), .full(a_full),
    .ovf_pulse(a_ovf), .unf_pulse(a_unf), .err_ovf(a_eo), .err_unf(a_eu));

  stack_ptr_unit #(.NUM_STACKS(3), .DEPTH(4),
                   .STACK_BASE({16'hFD00, 16'hFE00, 16'hFF00})) dut_b (
    .clk(clk), .rst(rst), .op_valid(b_op_valid), .op(b_op), .sel(b_sel),
    .err_clr(b_err_clr), .top_addr(b_top), .push_addr(b_push),
    .sp_all(b_sp_all), .cnt_all(b_cnt_all), .empty(b_empty), .full(b_full),
    .ovf_pulse(b_ovf), .unf_pulse(b_unf), .err_ovf(b_eo), .err_unf(b_eu));

  typedef struct packed {
    logic [1:0]  d;
    logic [47:0] sp;
    logic [26:0] cnt;
    logic [2:0]  emp, ful, eo, eu;
    logic        ovf, unf;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [15:0] m_sp   [2][3];
  logic [15:0] m_base [2][3];
  int          m_cnt  [2][3];
  logic [2:0]  m_eo [2], m_eu [2];
  int          nst [2] = '{2, 3};
  int          dep [2] = '{256, 4};

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, CLR = 2'b11;

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_base[d][0] = 16'hFF00;
      m_base[d][1] = 16'hFE00;
      m_base[d][2] = 16'hFD00;
      for (int i = 0; i < 3; i++) begin
        m_sp[d][i]  = m_base[d][i];
        m_cnt[d][i] = 0;
      end
      m_eo[d] = '0;
      m_eu[d] = '0;
    end
  endtask

  function automatic exp_t build(input int d);
    exp_t e;
    e = '0;
    e.d = 2'(d);
    for (int i = 0; i < nst[d]; i++) begin
      e.sp[i*16 +: 16] = m_sp[d][i];
      e.cnt[i*9 +: 9]  = 9'(m_cnt[d][i]);
      e.emp[i] = (m_cnt[d][i] == 0);
      e.ful[i] = (m_cnt[d][i] == dep[d]);
    end
    e.eo = m_eo[d];
    e.eu = m_eu[d];
    return e;
  endfunction

  function automatic exp_t observe(input logic [1:0] d);
    exp_t o;
    o = '0;
    o.d = d;
    if (d == 0) begin
      o.sp = {16'h0, a_sp_all};
      o.cnt = {9'h0, a_cnt_all};
      o.emp = {1'b0, a_empty}; o.ful = {1'b0, a_full};
      o.eo = {1'b0, a_eo};     o.eu = {1'b0, a_eu};
      o.ovf = a_ovf;           o.unf = a_unf;
    end else begin
      o.sp = b_sp_all;
      o.cnt = {6'h0, b_cnt_all[8:6], 6'h0, b_cnt_all[5:3], 6'h0, b_cnt_all[2:0]};
      o.emp = b_empty; o.ful = b_full;
      o.eo = b_eo;     o.eu = b_eu;
      o.ovf = b_ovf;   o.unf = b_unf;
    end
    return o;
  endfunction

  // Drive one cycle on instance d, push the modelled result, then score it.
  task automatic step(input int d, input logic v, input logic [1:0] o,
                      input int s, input logic c);
    exp_t e, ob;
    logic ovf, unf;
    logic [15:0] t_obs, p_obs;
    @(negedge clk);
    if (d == 0) begin
      a_op_valid = v; a_op = o; a_sel = s[0]; a_err_clr = c;
    end else begin
      b_op_valid = v; b_op = o; b_sel = s[1:0]; b_err_clr = c;
    end
    ovf = 0; unf = 0;
    if (c) begin m_eo[d] = '0; m_eu[d] = '0; end
    if (v && s < nst[d]) begin
      case (o)
        PUSH: if (m_cnt[d][s] < dep[d]) begin
                m_sp[d][s] = m_sp[d][s] - 16'd1; m_cnt[d][s]++;
              end else begin
                ovf = 1; m_eo[d][s] = 1'b1;
              end
        POP:  if (m_cnt[d][s] > 0) begin
                m_sp[d][s] = m_sp[d][s] + 16'd1; m_cnt[d][s]--;
              end else begin
                unf = 1; m_eu[d][s] = 1'b1;
              end
        CLR:  begin m_sp[d][s] = m_base[d][s]; m_cnt[d][s] = 0; end
        default: ;
      endcase
    end
    e = build(d); e.ovf = ovf; e.unf = unf;
    sbq.push_back(e);
    @(posedge clk); #1;
    e  = sbq.pop_front();
    ob = observe(e.d);
    n_tests++; if (ob.sp  !== e.sp)  begin n_fail++; $display("FAIL sp_all d=%0d got %h exp %h", d, ob.sp, e.sp); end
    n_tests++; if (ob.cnt !== e.cnt) begin n_fail++; $display("FAIL cnt_all d=%0d got %h exp %h", d, ob.cnt, e.cnt); end
    n_tests++; if (ob.emp !== e.emp) begin n_fail++; $display("FAIL empty d=%0d got %b exp %b", d, ob.emp, e.emp); end
    n_tests++; if (ob.ful !== e.ful) begin n_fail++; $display("FAIL full d=%0d got %b exp %b", d, ob.ful, e.ful); end
    n_tests++; if (ob.ovf !== e.ovf) begin n_fail++; $display("FAIL ovf_pulse d=%0d got %b exp %b", d, ob.ovf, e.ovf); end
    n_tests++; if (ob.unf !== e.unf) begin n_fail++; $display("FAIL unf_pulse d=%0d got %b exp %b", d, ob.unf, e.unf); end
    n_tests++; if (ob.eo  !== e.eo)  begin n_fail++; $display("FAIL err_ovf d=%0d got %b exp %b", d, ob.eo, e.eo); end
    n_tests++; if (ob.eu  !== e.eu)  begin n_fail++; $display("FAIL err_unf d=%0d got %b exp %b", d, ob.eu, e.eu); end
    if (s < nst[d]) begin
      t_obs = (d == 0) ? a_top : b_top;
      p_obs = (d == 0) ? a_push : b_push;
      n_tests++; if (t_obs !== m_sp[d][s]) begin n_fail++; $display("FAIL top_addr d=%0d got %h exp %h", d, t_obs, m_sp[d][s]); end
      n_tests++; if (p_obs !== m_sp[d][s] - 16'd1) begin n_fail++; $display("FAIL push_addr d=%0d got %h exp %h", d, p_obs, m_sp[d][s] - 16'd1); end
    end
    a_op_valid = 0; a_err_clr = 0;
    b_op_valid = 0; b_err_clr = 0;
  endtask

  task automatic test_reset();
    step(0, 0, NOP, 0, 0);
    step(1, 0, NOP, 0, 0);
    n_tests++; if (a_sp_all !== 32'hFE00FF00) begin n_fail++; $display("FAIL rst_sp got %h exp FE00FF00", a_sp_all); end
    n_tests++; if (a_cnt_all !== 18'h0) begin n_fail++; $display("FAIL rst_cnt got %h exp 0", a_cnt_all); end
    n_tests++; if (a_empty !== 2'b11 || a_full !== 2'b00) begin n_fail++; $display("FAIL rst_flags got e=%b f=%b exp e=11 f=00", a_empty, a_full); end
    n_tests++; if (a_top !== 16'hFF00 || a_push !== 16'hFEFF) begin n_fail++; $display("FAIL rst_addr got %h/%h exp FF00/FEFF", a_top, a_push); end
  endtask

  task automatic test_push_pop();
    repeat (3) step(0, 1, PUSH, 0, 0);
    n_tests++; if (a_sp_all[15:0] !== 16'hFEFD || a_cnt_all[8:0] !== 9'd3) begin n_fail++; $display("FAIL push3 got %h/%0d exp FEFD/3", a_sp_all[15:0], a_cnt_all[8:0]); end
    step(0, 1, POP, 0, 0);
    n_tests++; if (a_sp_all[15:0] !== 16'hFEFE || a_cnt_all[8:0] !== 9'd2) begin n_fail++; $display("FAIL pop got %h/%0d exp FEFE/2", a_sp_all[15:0], a_cnt_all[8:0]); end
    n_tests++; if (a_sp_all[31:16] !== 16'hFE00 || a_cnt_all[17:9] !== 9'd0) begin n_fail++; $display("FAIL other_stack got %h/%0d exp FE00/0", a_sp_all[31:16], a_cnt_all[17:9]); end
  endtask

  task automatic test_overflow();
    repeat (4) step(1, 1, PUSH, 1, 0);
    n_tests++; if (b_full !== 3'b010) begin n_fail++; $display("FAIL full_after4 got %b exp 010", b_full); end
    step(1, 1, PUSH, 1, 0);
    n_tests++; if (b_ovf !== 1'b1 || b_eo !== 3'b010) begin n_fail++; $display("FAIL ovf got p=%b e=%b exp 1/010", b_ovf, b_eo); end
    n_tests++; if (b_sp_all[31:16] !== 16'hFDFC) begin n_fail++; $display("FAIL ovf_sp got %h exp FDFC", b_sp_all[31:16]); end
    step(1, 0, NOP, 1, 0);
    n_tests++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b exp 0", b_ovf); end
  endtask

  task automatic test_underflow_errclr();
    step(1, 1, POP, 0, 0);
    n_tests++; if (b_unf !== 1'b1 || b_eu !== 3'b001 || b_sp_all[15:0] !== 16'hFF00) begin n_fail++; $display("FAIL unf got p=%b e=%b sp=%h exp 1/001/FF00", b_unf, b_eu, b_sp_all[15:0]); end
    step(1, 1, PUSH, 1, 1);
    n_tests++; if (b_eu !== 3'b000 || b_eo !== 3'b010 || b_ovf !== 1'b1) begin n_fail++; $display("FAIL errclr got eu=%b eo=%b p=%b exp 000/010/1", b_eu, b_eo, b_ovf); end
  endtask

  task automatic test_back_to_back();
    step(1, 1, PUSH, 1, 0);
    step(1, 1, PUSH, 1, 0);
    n_tests++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf got %b exp 1", b_ovf); end
    step(1, 1, PUSH, 0, 0);
    n_tests++; if (b_ovf !== 1'b0 || b_cnt_all[2:0] !== 3'd1) begin n_fail++; $display("FAIL b2b_recover got p=%b cnt=%0d exp 0/1", b_ovf, b_cnt_all[2:0]); end
  endtask

  task automatic test_clear();
    step(0, 1, CLR, 0, 0);
    n_tests++; if (a_sp_all[15:0] !== 16'hFF00 || a_cnt_all[8:0] !== 9'd0 || a_ovf || a_unf) begin n_fail++; $display("FAIL clear got %h/%0d p=%b%b exp FF00/0/00", a_sp_all[15:0], a_cnt_all[8:0], a_ovf, a_unf); end
    step(1, 1, CLR, 1, 0);
    n_tests++; if (b_eo !== 3'b010 || b_full !== 3'b000) begin n_fail++; $display("FAIL clear_sticky got eo=%b full=%b exp 010/000", b_eo, b_full); end
    step(1, 1, PUSH, 3, 0);
    n_tests++; if (b_sp_all[47:32] !== 16'hFD00 || b_ovf !== 1'b0) begin n_fail++; $display("FAIL bad_sel got %h p=%b exp FD00/0", b_sp_all[47:32], b_ovf); end
    step(1, 0, PUSH, 2, 0);
    step(1, 1, NOP, 2, 0);
  endtask

  task automatic test_async_reset();
    step(0, 1, PUSH, 0, 0);
    step(0, 1, PUSH, 0, 0);
    @(negedge clk);
    a_op_valid = 1; a_op = PUSH; a_sel = 0;
    #2 rst = 0;
    #1;
    n_tests++; if (a_sp_all !== 32'hFE00FF00 || a_cnt_all !== 18'h0 || a_empty !== 2'b11) begin n_fail++; $display("FAIL async_rst got %h/%h/%b exp FE00FF00/0/11", a_sp_all, a_cnt_all, a_empty); end
    n_tests++; if (b_eo !== 3'b000 || b_sp_all !== 48'hFD00FE00FF00) begin n_fail++; $display("FAIL async_rst_b got %b/%h exp 000/FD00FE00FF00", b_eo, b_sp_all); end
    @(posedge clk);
    @(negedge clk);
    a_op_valid = 0;
    rst = 1;
    reset_model();
    step(0, 1, PUSH, 0, 0);
    n_tests++; if (a_sp_all[15:0] !== 16'hFEFF || a_cnt_all[8:0] !== 9'd1) begin n_fail++; $display("FAIL post_rst got %h/%0d exp FEFF/1", a_sp_all[15:0], a_cnt_all[8:0]); end
  endtask

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow_errclr();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
